// File: rtl/measure_fsm_arbiter.sv
// ---------------------------------------------------------------------------
// measure_fsm_arbiter
//
// Shares a single Measure-FSM (I2C query engine) between four sensor-FSM
// requesters. Single-cycle query pulses from each requester are latched into
// a pending vector. The engine is granted round-robin. Exactly one query pulse
// goes out per transaction. Done/Error and the two result bytes are routed
// back to the granted requester. A watchdog ends a transaction that never
// completes. One idle gap cycle always separates two engine transactions.
//
// Ports:
//   Reset_n_i                 async active-low reset
//   Clk_i                     rising-edge clock
//   Enable_i                  arbiter enable
//   ReqQueryLocal_i[3:0]      per-requester local-query pulse
//   ReqQueryRemote_i[3:0]     per-requester remote-query pulse
//   ReqDone_o[3:0]            per-requester completion pulse (one-hot/zero)
//   ReqError_o[3:0]           per-requester error pulse (one-hot/zero)
//   ReqByte0_o/ReqByte1_o     last successfully captured result bytes
//   MeasureFSM_QueryLocal_o   local-query pulse to the engine
//   MeasureFSM_QueryRemote_o  remote-query pulse to the engine
//   MeasureFSM_Done_i         engine done
//   MeasureFSM_Error_i        engine error
//   MeasureFSM_Byte0_i/1_i    engine result bytes
//   ParamTimeout_i            watchdog length in cycles, 0 disables it
//   Grant_o[1:0]              current or last granted requester
//   Busy_o                    transaction in flight (wait or gap)
//   TimeoutIntr_o             one-cycle pulse when the watchdog fires
//   Overrun_o                 sticky: query arrived while already pending
// ---------------------------------------------------------------------------
module measure_fsm_arbiter #(
    parameter int DataWidth    = 8,
    parameter int TimeoutWidth = 16
) (
    input  logic                    Reset_n_i,
    input  logic                    Clk_i,
    input  logic                    Enable_i,
    input  logic [3:0]              ReqQueryLocal_i,
    input  logic [3:0]              ReqQueryRemote_i,
    output logic [3:0]              ReqDone_o,
    output logic [3:0]              ReqError_o,
    output logic [DataWidth-1:0]    ReqByte0_o,
    output logic [DataWidth-1:0]    ReqByte1_o,
    output logic                    MeasureFSM_QueryLocal_o,
    output logic                    MeasureFSM_QueryRemote_o,
    input  logic                    MeasureFSM_Done_i,
    input  logic                    MeasureFSM_Error_i,
    input  logic [DataWidth-1:0]    MeasureFSM_Byte0_i,
    input  logic [DataWidth-1:0]    MeasureFSM_Byte1_i,
    input  logic [TimeoutWidth-1:0] ParamTimeout_i,
    output logic [1:0]              Grant_o,
    output logic                    Busy_o,
    output logic                    TimeoutIntr_o,
    output logic                    Overrun_o
);

    typedef enum logic [1:0] {
        stDisabled,
        stIdle,
        stWait,
        stGap
    } state_t;

    state_t                  state_q,    state_d;
    logic [3:0]              pending_q,  pending_d;
    logic [3:0]              kind_q,     kind_d;
    logic [1:0]              last_q,     last_d;
    logic [1:0]              grant_q,    grant_d;
    logic [TimeoutWidth-1:0] timer_q,    timer_d;
    logic                    err_flag_q, err_flag_d;
    logic                    overrun_q,  overrun_d;
    logic [DataWidth-1:0]    byte0_q,    byte0_d;
    logic [DataWidth-1:0]    byte1_q,    byte1_d;

    logic       any_pending;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       query_local;
    logic       query_remote;
    logic       timeout_fire;

    // Round-robin search starting after the last served requester. Walking
    // the offsets from 4 down to 1 lets the nearest pending index win.
    always_comb begin
        winner      = last_q;
        any_pending = 1'b0;
        idx         = last_q;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + 2'(k);
            if (pending_q[idx]) begin
                winner      = idx;
                any_pending = 1'b1;
            end
        end
    end

    // Next-state logic. Request capture is evaluated first so that the
    // state-specific clears below (grant, disable) take precedence.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        kind_d       = kind_q;
        last_d       = last_q;
        grant_d      = grant_q;
        timer_d      = timer_q;
        err_flag_d   = err_flag_q;
        overrun_d    = overrun_q;
        byte0_d      = byte0_q;
        byte1_d      = byte1_q;
        query_local  = 1'b0;
        query_remote = 1'b0;
        timeout_fire = 1'b0;

        if (state_q != stDisabled) begin
            for (int i = 0; i < 4; i++) begin
                if (ReqQueryLocal_i[i] || ReqQueryRemote_i[i]) begin
                    if (pending_q[i]) begin
                        overrun_d = 1'b1;
                    end else begin
                        pending_d[i] = 1'b1;
                        // Local wins a same-cycle collision.
                        kind_d[i]    = ReqQueryRemote_i[i] & ~ReqQueryLocal_i[i];
                    end
                end
            end
        end

        case (state_q)
            stDisabled: begin
                pending_d = '0;
                overrun_d = 1'b0;
                if (Enable_i) begin
                    state_d = stIdle;
                end
            end
            stIdle: begin
                if (!Enable_i) begin
                    pending_d = '0;
                    state_d   = stDisabled;
                end else if (any_pending) begin
                    query_local       = ~kind_q[winner];
                    query_remote      = kind_q[winner];
                    grant_d           = winner;
                    pending_d[winner] = 1'b0;
                    timer_d           = ParamTimeout_i;
                    state_d           = stWait;
                end
            end
            stWait: begin
                // The engine cannot be cancelled, so Enable_i is not looked at.
                if (MeasureFSM_Error_i) begin
                    err_flag_d = 1'b1;
                    state_d    = stGap;
                end else if (MeasureFSM_Done_i) begin
                    byte0_d    = MeasureFSM_Byte0_i;
                    byte1_d    = MeasureFSM_Byte1_i;
                    err_flag_d = 1'b0;
                    state_d    = stGap;
                end else if ((ParamTimeout_i != '0) && (timer_q == TimeoutWidth'(1))) begin
                    timeout_fire = 1'b1;
                    err_flag_d   = 1'b1;
                    state_d      = stGap;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TimeoutWidth'(1);
                end
            end
            stGap: begin
                last_d  = grant_q;
                state_d = Enable_i ? stIdle : stDisabled;
            end
            default: begin
                state_d = stDisabled;
            end
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q    <= stDisabled;
            pending_q  <= '0;
            kind_q     <= '0;
            last_q     <= 2'd3;
            grant_q    <= '0;
            timer_q    <= '0;
            err_flag_q <= 1'b0;
            overrun_q  <= 1'b0;
            byte0_q    <= '0;
            byte1_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            kind_q     <= kind_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            timer_q    <= timer_d;
            err_flag_q <= err_flag_d;
            overrun_q  <= overrun_d;
            byte0_q    <= byte0_d;
            byte1_q    <= byte1_d;
        end
    end

    // Completion pulses come straight from the registered gap state, so they
    // are one-hot by construction.
    assign ReqDone_o  = (state_q == stGap && !err_flag_q) ? (4'b0001 << grant_q) : 4'b0000;
    assign ReqError_o = (state_q == stGap &&  err_flag_q) ? (4'b0001 << grant_q) : 4'b0000;
    assign ReqByte0_o = byte0_q;
    assign ReqByte1_o = byte1_q;

    assign MeasureFSM_QueryLocal_o  = query_local;
    assign MeasureFSM_QueryRemote_o = query_remote;
    assign TimeoutIntr_o            = timeout_fire;

    assign Grant_o   = grant_q;
    assign Busy_o    = (state_q == stWait) || (state_q == stGap);
    assign Overrun_o = overrun_q;

endmodule

// File: tb/tb_measure_fsm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_measure_fsm_arbiter
//
// Directed scenarios followed by a randomized phase. The random phase keeps a
// transaction-level picture of the arbiter: a set of pending requesters with
// their query kind, the last served requester and the overrun flag.
// ---------------------------------------------------------------------------
module tb_measure_fsm_arbiter;

    localparam int DW = 8;
    localparam int TW = 16;

    logic          Reset_n_i;
    logic          Clk_i;
    logic          Enable_i;
    logic [3:0]    ReqQueryLocal_i;
    logic [3:0]    ReqQueryRemote_i;
    logic [3:0]    ReqDone_o;
    logic [3:0]    ReqError_o;
    logic [DW-1:0] ReqByte0_o;
    logic [DW-1:0] ReqByte1_o;
    logic          MeasureFSM_QueryLocal_o;
    logic          MeasureFSM_QueryRemote_o;
    logic          MeasureFSM_Done_i;
    logic          MeasureFSM_Error_i;
    logic [DW-1:0] MeasureFSM_Byte0_i;
    logic [DW-1:0] MeasureFSM_Byte1_i;
    logic [TW-1:0] ParamTimeout_i;
    logic [1:0]    Grant_o;
    logic          Busy_o;
    logic          TimeoutIntr_o;
    logic          Overrun_o;

    int nChecks = 0;
    int nFail   = 0;

    // Reference picture of the arbiter used by the randomized phase.
    bit [3:0]      mPending;
    bit [3:0]      mKind;
    int            mLast;
    bit            mOverrun;
    logic [DW-1:0] expB0;
    logic [DW-1:0] expB1;

    measure_fsm_arbiter #(
        .DataWidth   (DW),
        .TimeoutWidth(TW)
    ) dut (
        .Reset_n_i               (Reset_n_i),
        .Clk_i                   (Clk_i),
        .Enable_i                (Enable_i),
        .ReqQueryLocal_i         (ReqQueryLocal_i),
        .ReqQueryRemote_i        (ReqQueryRemote_i),
        .ReqDone_o               (ReqDone_o),
        .ReqError_o              (ReqError_o),
        .ReqByte0_o              (ReqByte0_o),
        .ReqByte1_o              (ReqByte1_o),
        .MeasureFSM_QueryLocal_o (MeasureFSM_QueryLocal_o),
        .MeasureFSM_QueryRemote_o(MeasureFSM_QueryRemote_o),
        .MeasureFSM_Done_i       (MeasureFSM_Done_i),
        .MeasureFSM_Error_i      (MeasureFSM_Error_i),
        .MeasureFSM_Byte0_i      (MeasureFSM_Byte0_i),
        .MeasureFSM_Byte1_i      (MeasureFSM_Byte1_i),
        .ParamTimeout_i          (ParamTimeout_i),
        .Grant_o                 (Grant_o),
        .Busy_o                  (Busy_o),
        .TimeoutIntr_o           (TimeoutIntr_o),
        .Overrun_o               (Overrun_o)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    // Absolute time limit so a stuck run still reports.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=no end of test expected=end within time limit");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] loc, input logic [3:0] rem,
                                 input logic done, input logic err,
                                 input logic [DW-1:0] b0, input logic [DW-1:0] b1);
        ReqQueryLocal_i    = loc;
        ReqQueryRemote_i   = rem;
        MeasureFSM_Done_i  = done;
        MeasureFSM_Error_i = err;
        MeasureFSM_Byte0_i = b0;
        MeasureFSM_Byte1_i = b1;
    endtask

    task automatic modelCapture(input logic [3:0] loc, input logic [3:0] rem);
        for (int i = 0; i < 4; i++) begin
            if (loc[i] || rem[i]) begin
                if (mPending[i]) mOverrun = 1'b1;
                else begin
                    mPending[i] = 1'b1;
                    mKind[i]    = !loc[i];
                end
            end
        end
    endtask

    // Next requester after mLast in cyclic order, or -1 when nothing waits.
    function automatic int modelWinner();
        for (int k = 1; k <= 4; k++) begin
            int cand;
            cand = (mLast + k) % 4;
            if (mPending[cand]) return cand;
        end
        return -1;
    endfunction

    task automatic doReset();
        Reset_n_i      = 1'b0;
        Enable_i       = 1'b0;
        ParamTimeout_i = '0;
        applyStimulus(4'b0, 4'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) tick();
        checkOutput("resetOutputs",
                    {1'b0, ReqDone_o, ReqError_o, ReqByte0_o, ReqByte1_o, MeasureFSM_QueryLocal_o,
                     MeasureFSM_QueryRemote_o, Grant_o, Busy_o, TimeoutIntr_o, Overrun_o}, 32'h0);
        Reset_n_i = 1'b1;
        Enable_i  = 1'b1;
        expB0     = '0;
        expB1     = '0;
        tick();
    endtask

    // Drive a request pulse in an idle cycle with nothing pending; on return
    // the bench sits in the cycle where the engine query is expected.
    task automatic pulseIdle(input logic [3:0] loc, input logic [3:0] rem);
        applyStimulus(loc, rem, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        checkOutput("noQueryBeforeCapture", {MeasureFSM_QueryLocal_o, MeasureFSM_QueryRemote_o}, 0);
        tick();
        applyStimulus(4'b0, 4'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // One full transaction starting in the query cycle and ending in the
    // cycle after the gap. resp: 0 done, 1 error, 2 watchdog timeout.
    task automatic runTransaction(input int expWin, input bit expRemote, input int waitCycles,
                                  input int resp, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                  input bit randPulses, input logic [3:0] waitLocal, input bit dropEnable);
        #1;
        checkOutput("queryLocal", MeasureFSM_QueryLocal_o, 32'(!expRemote));
        checkOutput("queryRemote", MeasureFSM_QueryRemote_o, 32'(expRemote));
        checkOutput("busyAtQuery", Busy_o, 0);
        tick();
        checkOutput("grant", Grant_o, expWin);
        for (int c = 1; c <= waitCycles; c++) begin
            logic [3:0] l;
            logic [3:0] r;
            l = 4'b0;
            r = 4'b0;
            if (randPulses && $urandom_range(0, 2) == 0) begin
                l = 4'($urandom);
                r = 4'($urandom);
            end
            if (c == 1) begin
                l = l | waitLocal;
                if (dropEnable) Enable_i = 1'b0;
            end
            applyStimulus(l, r, (c == waitCycles) && (resp == 0), (c == waitCycles) && (resp == 1), b0, b1);
            #1;
            checkOutput("busyInWait", Busy_o, 1);
            checkOutput("noQueryInWait", {MeasureFSM_QueryLocal_o, MeasureFSM_QueryRemote_o}, 0);
            checkOutput("noReqPulseInWait", {ReqDone_o, ReqError_o}, 0);
            checkOutput("timeoutIntr", TimeoutIntr_o, 32'((resp == 2) && (c == waitCycles)));
            if (randPulses) modelCapture(l, r);
            tick();
        end
        applyStimulus(4'b0, 4'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        if (resp == 0) begin
            expB0 = b0;
            expB1 = b1;
        end
        #1;
        checkOutput("gapDone", ReqDone_o, (resp == 0) ? (32'd1 << expWin) : 32'd0);
        checkOutput("gapError", ReqError_o, (resp != 0) ? (32'd1 << expWin) : 32'd0);
        checkOutput("gapBytes", {ReqByte1_o, ReqByte0_o}, {expB1, expB0});
        checkOutput("gapNoQuery", {MeasureFSM_QueryLocal_o, MeasureFSM_QueryRemote_o, TimeoutIntr_o}, 0);
        checkOutput("busyInGap", Busy_o, 1);
        mLast = expWin;
        tick();
    endtask

    initial begin
        int win;
        int resp;
        logic [3:0] l;
        logic [3:0] r;

        // Single local request with known result bytes.
        doReset();
        pulseIdle(4'b0001, 4'b0000);
        runTransaction(0, 1'b0, 4, 0, 8'h34, 8'h12, 1'b0, 4'b0, 1'b0);
        checkOutput("idleAfterSingle", {Busy_o, ReqDone_o}, 0);

        // Round-robin from a fresh reset, then a partial re-request.
        doReset();
        pulseIdle(4'b1111, 4'b0000);
        runTransaction(0, 1'b0, 3, 0, 8'hA0, 8'h0A, 1'b0, 4'b0, 1'b0);
        runTransaction(1, 1'b0, 3, 0, 8'hA1, 8'h1A, 1'b0, 4'b0, 1'b0);
        runTransaction(2, 1'b0, 3, 0, 8'hA2, 8'h2A, 1'b0, 4'b0, 1'b0);
        runTransaction(3, 1'b0, 3, 0, 8'hA3, 8'h3A, 1'b0, 4'b0, 1'b0);
        pulseIdle(4'b0101, 4'b0000);
        runTransaction(0, 1'b0, 2, 0, 8'hB0, 8'h0B, 1'b0, 4'b0, 1'b0);
        runTransaction(2, 1'b0, 2, 0, 8'hB2, 8'h2B, 1'b0, 4'b0, 1'b0);

        // Same-cycle local/remote collision, then a repeat pulse while pending.
        pulseIdle(4'b0100, 4'b0100);
        applyStimulus(4'b0000, 4'b0100, 1'b0, 1'b0, 8'h00, 8'h00);
        runTransaction(2, 1'b0, 2, 0, 8'hC2, 8'h2C, 1'b0, 4'b0, 1'b0);
        checkOutput("overrunSet", Overrun_o, 1);
        checkOutput("noExtraTransaction", {MeasureFSM_QueryLocal_o, MeasureFSM_QueryRemote_o, Busy_o}, 0);

        // Engine error keeps the previous bytes.
        pulseIdle(4'b0010, 4'b0000);
        runTransaction(1, 1'b0, 3, 1, 8'hEE, 8'hFF, 1'b0, 4'b0, 1'b0);

        // Watchdog of 4 cycles on a remote query.
        ParamTimeout_i = 16'd4;
        pulseIdle(4'b0000, 4'b1000);
        runTransaction(3, 1'b1, 4, 2, 8'h55, 8'h66, 1'b0, 4'b0, 1'b0);
        ParamTimeout_i = 16'd0;

        // Watchdog disabled: a long wait ends only on Done.
        pulseIdle(4'b0001, 4'b0000);
        runTransaction(0, 1'b0, 30, 0, 8'h77, 8'h88, 1'b0, 4'b0, 1'b0);

        // Disable while requester 1 is in flight with requester 3 pending.
        pulseIdle(4'b0010, 4'b0000);
        runTransaction(1, 1'b0, 3, 0, 8'h91, 8'h19, 1'b0, 4'b1000, 1'b1);
        checkOutput("busyDisabled", Busy_o, 0);
        tick();
        checkOutput("overrunClearedDisabled", Overrun_o, 0);
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 4; c++) begin
            tick();
            applyStimulus(4'b0, 4'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            checkOutput("noQueryDisabled", {MeasureFSM_QueryLocal_o, MeasureFSM_QueryRemote_o}, 0);
        end
        Enable_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("noStaleAfterEnable", {MeasureFSM_QueryLocal_o, MeasureFSM_QueryRemote_o, Busy_o}, 0);
        end

        // Asynchronous reset in the middle of a wait.
        pulseIdle(4'b0100, 4'b0000);
        #1;
        checkOutput("queryBeforeReset", MeasureFSM_QueryLocal_o, 1);
        tick();
        tick();
        Reset_n_i = 1'b0;
        #1;
        checkOutput("asyncResetOutputs",
                    {1'b0, ReqDone_o, ReqError_o, ReqByte0_o, ReqByte1_o, MeasureFSM_QueryLocal_o,
                     MeasureFSM_QueryRemote_o, Grant_o, Busy_o, TimeoutIntr_o, Overrun_o}, 32'h0);
        doReset();
        pulseIdle(4'b1000, 4'b0000);
        runTransaction(3, 1'b0, 2, 0, 8'hD3, 8'h3D, 1'b0, 4'b0, 1'b0);
        checkOutput("noStaleAfterReset", {MeasureFSM_QueryLocal_o, MeasureFSM_QueryRemote_o, Busy_o}, 0);

        // Randomized traffic against the transaction-level picture.
        mPending = '0;
        mKind    = '0;
        mLast    = 3;
        mOverrun = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (mPending == 4'b0) begin
                l = 4'($urandom);
                r = 4'($urandom);
                if ((l | r) == 4'b0) l = 4'b0001;
                modelCapture(l, r);
                pulseIdle(l, r);
            end
            win = modelWinner();
            if (win < 0) begin
                checkOutput("modelHasWinner", 32'(win), 0);
                break;
            end
            mPending[win] = 1'b0;
            resp = ($urandom_range(0, 3) == 0) ? 1 : 0;
            runTransaction(win, mKind[win], $urandom_range(1, 6), resp,
                           8'($urandom), 8'($urandom), 1'b1, 4'b0, 1'b0);
            checkOutput("randOverrun", Overrun_o, 32'(mOverrun));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/measure_fsm_arbiter.md
Name: measure_fsm_arbiter

Overview:
- Shares one Measure-FSM (the I2C query engine) between four sensor-FSM requesters.
- Latches single-cycle QueryLocal/QueryRemote pulses from each requester and grants the engine round-robin.
- Forwards exactly one query pulse per transaction and routes Done/Error plus the two result bytes back to the granted requester.
- Adds a transaction timeout watchdog and enforces the mandatory one-cycle idle gap between Measure-FSM transactions.

Parameters:
- DataWidth, 8, width of each result byte
- TimeoutWidth, 16, width of the timeout counter and ParamTimeout_i

Ports:
- Reset_n_i  input  1  asynchronous reset, active-low
- Clk_i  input  1  clock, rising edge
- Enable_i  input  1  arbiter enable
- ReqQueryLocal_i  input  4  per-requester local-query pulse
- ReqQueryRemote_i  input  4  per-requester remote-query pulse
- ReqDone_o  output  4  per-requester completion pulse
- ReqError_o  output  4  per-requester error pulse (I2C error or timeout)
- ReqByte0_o  output  DataWidth  captured Byte0, shared by all requesters
- ReqByte1_o  output  DataWidth  captured Byte1, shared by all requesters
- MeasureFSM_QueryLocal_o  output  1  local-query pulse to Measure-FSM
- MeasureFSM_QueryRemote_o  output  1  remote-query pulse to Measure-FSM
- MeasureFSM_Done_i  input  1  Measure-FSM done
- MeasureFSM_Error_i  input  1  Measure-FSM error
- MeasureFSM_Byte0_i  input  DataWidth  Measure-FSM result byte 0
- MeasureFSM_Byte1_i  input  DataWidth  Measure-FSM result byte 1
- ParamTimeout_i  input  TimeoutWidth  timeout in cycles; 0 disables the watchdog
- Grant_o  output  2  index of the current or last granted requester
- Busy_o  output  1  transaction in flight
- TimeoutIntr_o  output  1  single-cycle pulse when a timeout fires
- Overrun_o  output  1  sticky flag: a query arrived while that requester was already pending

Behaviour:
- Reset: all outputs 0. Pending[3:0]=0, Kind[3:0]=0, Last=3 (requester 0 wins first), state stDisabled.
- Request capture (stIdle, stWait, stGap only):
  - A pulse on ReqQueryLocal_i[i] or ReqQueryRemote_i[i] sets Pending[i] at the next edge.
  - Kind[i] is 1 for remote, 0 for local. If both pulse in the same cycle, local wins and remote is dropped.
  - A pulse while Pending[i]=1 is ignored and sets Overrun_o. Overrun_o clears only on reset or in stDisabled.
  - A pulse from the granted requester during its own transaction is captured normally.
- States:
  - stDisabled:
    - Pending and Overrun_o are cleared; query pulses are ignored.
    - Enable_i=1 -> stIdle.
  - stIdle:
    - Enable_i=0 -> stDisabled, pending cleared.
    - Otherwise, if any Pending bit is set: winner = first set index searching Last+1, Last+2, ... modulo 4.
    - In the same cycle (combinational Mealy output): assert MeasureFSM_QueryLocal_o or MeasureFSM_QueryRemote_o per Kind[winner] for exactly 1 cycle.
    - Next edge: Grant_o<=winner, Pending[winner]<=0, timer<=ParamTimeout_i, -> stWait.
  - stWait:
    - Busy_o=1. Priority order: Error_i, then Done_i, then timeout.
    - MeasureFSM_Error_i=1: set ErrFlag, -> stGap.
    - Else MeasureFSM_Done_i=1: capture Byte0/Byte1 into ReqByte0_o/ReqByte1_o, clear ErrFlag, -> stGap.
    - Else ParamTimeout_i!=0 and timer==1: TimeoutIntr_o=1 this cycle, set ErrFlag, -> stGap.
    - Otherwise the timer decrements.
    - Enable_i=0 does not abort an in-flight transaction, because the Measure-FSM cannot be cancelled.
  - stGap (exactly 1 cycle):
    - Busy_o=1.
    - ErrFlag=0: ReqDone_o[Grant_o]=1; the byte outputs are already valid this cycle.
    - ErrFlag=1: ReqError_o[Grant_o]=1; bytes unchanged.
    - Last<=Grant_o.
    - Enable_i=1 -> stIdle; Enable_i=0 -> stDisabled.
- Timing:
  - Query latency: requester pulse in cycle N -> Measure-FSM query in cycle N+1 if the arbiter is idle.
  - Back-to-back grants are separated by at least 1 cycle in which both Measure-FSM query outputs are 0 (the stGap cycle).
- Stray inputs: Done_i/Error_i in stIdle, stGap or stDisabled are ignored.
- Output encoding: all ReqDone_o/ReqError_o bits are one-hot or zero. Byte outputs hold their value until the next successful Done.
- Reset mid-operation: asynchronous return to reset values; the Measure-FSM is expected to be reset by the same Reset_n_i.

Test Plan:
- Single request: Enable_i=1, ReqQueryLocal_i=0001 pulse at cycle 0 -> MeasureFSM_QueryLocal_o=1 at cycle 1 only. Done_i with Byte0=0x34, Byte1=0x12 at cycle 5 -> ReqDone_o=0001 at cycle 6 with ReqByte1_o/ReqByte0_o=0x12/0x34.
- Round-robin: pulse 1111 at once, each Done after 3 cycles -> grants in order 0,1,2,3. Then re-request 0 and 2 -> grant 0 then 2. Every grant is preceded by a 1-cycle gap.
- Kind and collision: ReqQueryRemote_i[2] and ReqQueryLocal_i[2] pulse in the same cycle -> only MeasureFSM_QueryLocal_o pulses. A second pulse on [2] while pending -> Overrun_o=1 and no extra transaction.
- Error and timeout:
  - Error_i during requester 1's transaction -> ReqError_o=0010 and bytes unchanged.
  - ParamTimeout_i=4 with no Done -> TimeoutIntr_o at the 4th wait cycle, then ReqError_o pulse.
  - ParamTimeout_i=0 with no Done -> waits indefinitely.
- Disable mid-transaction: Enable_i=0 during stWait with requester 3 pending -> current transaction completes with ReqDone_o, then stDisabled, Pending cleared, and no further queries.
- Reset: assert Reset_n_i=0 during stWait -> all outputs 0 immediately. After release, a pulse on 1000 is served with no stale pending.
